// File: rtl/la_gpio_pkg.sv
// Shared constants, IRQ mode encodings and the per-pin IRQ event helper
// for the GPIO input filter (la_gpio_infilter and its sub-blocks).
package la_gpio_pkg;

  localparam int N_DEF     = 8;
  localparam int SYNCW_DEF = 2;
  localparam int DBW_DEF   = 8;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    LEVEL     = 2'd2
  } irq_mode_e;

  // cur = filtered value now, nxt = filtered value after this edge.
  // LEVEL looks at cur only: active while the pin sits at pol.
  function automatic logic irq_hit(
    irq_mode_e m,
    logic      cur,
    logic      nxt,
    logic      pol
  );
    irq_hit = 1'b0;
    unique case (m)
      EDGE_RISE: irq_hit = ~cur & nxt;
      EDGE_FALL: irq_hit = cur & ~nxt;
      LEVEL:     irq_hit = cur ~^ pol;
      default:   irq_hit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/la_dsync.sv
// Single-bit pad synchronizer: SYNCW flops, async active-low reset.
// Ports: clk, nreset, in (async), out (synchronized). TARGET picks the cell.
module la_dsync #(
  parameter int SYNCW  = 2,
  parameter     TARGET = "DEFAULT"
) (
  input  logic clk,
  input  logic nreset,
  input  logic in,
  output logic out
);

  logic [SYNCW-1:0] sync_q;

  if (TARGET == "DEFAULT") begin : g_generic
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) sync_q <= '0;
      else         sync_q <= {sync_q[SYNCW-2:0], in};
    end
  end else begin : g_target
    // Targets without a dedicated sync cell share the plain flop chain.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) sync_q <= '0;
      else         sync_q <= {sync_q[SYNCW-2:0], in};
    end
  end

  assign out = sync_q[SYNCW-1];

endmodule

// File: rtl/la_gpio_debounce.sv
// One pin's debounce counter plus filtered flop.
// Ports: s_i (synced pin), en_i, limit_i; filt_o (filtered), filt_d_o (next).
module la_gpio_debounce
  import la_gpio_pkg::*;
#(
  parameter int DBW = DBW_DEF
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           s_i,
  input  logic           en_i,
  input  logic [DBW-1:0] limit_i,
  output logic           filt_o,
  output logic           filt_d_o
);

  logic [DBW-1:0] cnt_q, cnt_d;
  logic           filt_q, filt_d;
  logic           bypass;
  logic           hit;

  assign bypass = !en_i || (limit_i == '0);

  // >= keeps a running count safe when limit_i drops below it.
  // The count tops out at limit_i-1, so it cannot wrap.
  assign hit = cnt_q >= (limit_i - DBW'(1));

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (bypass) begin
      filt_d = s_i;
      cnt_d  = '0;
    end else if (s_i == filt_q) begin
      cnt_d  = '0;
    end else if (hit) begin
      filt_d = s_i;
      cnt_d  = '0;
    end else begin
      cnt_d  = cnt_q + DBW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o   = filt_q;
  assign filt_d_o = filt_d;

endmodule

// File: rtl/la_gpio_infilter.sv
// GPIO input conditioning: sync, debounce, edge detect, sticky IRQ pending.
// Ports: pad_in, db_en/db_limit, irq_*_en/mask/clear -> gpio_in, irq_pending,
// gpio_irq. Define LA_GPIO_LEVEL_IRQ_EN to add irq_level/irq_pol level IRQs.
module la_gpio_infilter
  import la_gpio_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SYNCW  = SYNCW_DEF,
  parameter int DBW    = DBW_DEF,
  parameter     TARGET = "DEFAULT"
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [N-1:0]   pad_in,
  input  logic [N-1:0]   db_en,
  input  logic [DBW-1:0] db_limit,
  input  logic [N-1:0]   irq_rise_en,
  input  logic [N-1:0]   irq_fall_en,
  input  logic [N-1:0]   irq_mask,
  input  logic [N-1:0]   irq_clear,
`ifdef LA_GPIO_LEVEL_IRQ_EN
  input  logic [N-1:0]   irq_level,
  input  logic [N-1:0]   irq_pol,
`endif
  output logic [N-1:0]   gpio_in,
  output logic [N-1:0]   irq_pending,
  output logic           gpio_irq
);

  logic [N-1:0] s;
  logic [N-1:0] filt_q, filt_d;
  logic [N-1:0] set;
  logic [N-1:0] pend_q, pend_d;
  logic         irq_q, irq_d;

  for (genvar i = 0; i < N; i++) begin : g_pin
    logic edge_set;

    la_dsync #(
      .SYNCW  (SYNCW),
      .TARGET (TARGET)
    ) u_sync (
      .clk    (clk),
      .nreset (nreset),
      .in     (pad_in[i]),
      .out    (s[i])
    );

    la_gpio_debounce #(
      .DBW (DBW)
    ) u_db (
      .clk      (clk),
      .nreset   (nreset),
      .s_i      (s[i]),
      .en_i     (db_en[i]),
      .limit_i  (db_limit),
      .filt_o   (filt_q[i]),
      .filt_d_o (filt_d[i])
    );

    assign edge_set =
      (irq_rise_en[i] & irq_hit(EDGE_RISE, filt_q[i], filt_d[i], 1'b0)) |
      (irq_fall_en[i] & irq_hit(EDGE_FALL, filt_q[i], filt_d[i], 1'b0));

`ifdef LA_GPIO_LEVEL_IRQ_EN
    assign set[i] = irq_level[i]
      ? irq_hit(LEVEL, filt_q[i], filt_d[i], irq_pol[i])
      : edge_set;
`else
    assign set[i] = edge_set;
`endif
  end

  // Set wins over clear so an edge coincident with W1C is kept.
  assign pend_d = (pend_q & ~irq_clear) | set;
  assign irq_d  = |(pend_q & ~irq_mask);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign gpio_in     = filt_q;
  assign irq_pending = pend_q;
  assign gpio_irq    = irq_q;

endmodule

// File: tb/tb_la_gpio_infilter.sv
// Scoreboard bench for la_gpio_infilter: directed scenarios plus random
// stimulus, compared each cycle against a run-length reference model.
module tb_la_gpio_infilter;

  localparam int N     = 8;
  localparam int SYNCW = 2;
  localparam int DBW   = 8;

  logic           clk = 1'b0;
  logic           nreset;
  logic [N-1:0]   pad_in, db_en;
  logic [DBW-1:0] db_limit;
  logic [N-1:0]   irq_rise_en, irq_fall_en, irq_mask, irq_clear;
  logic [N-1:0]   irq_level, irq_pol;
  logic [N-1:0]   gpio_in, irq_pending;
  logic           gpio_irq;

  always #5 clk = ~clk;

  la_gpio_infilter #(
    .N (N), .SYNCW (SYNCW), .DBW (DBW), .TARGET ("DEFAULT")
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .pad_in      (pad_in),
    .db_en       (db_en),
    .db_limit    (db_limit),
    .irq_rise_en (irq_rise_en),
    .irq_fall_en (irq_fall_en),
    .irq_mask    (irq_mask),
    .irq_clear   (irq_clear),
`ifdef LA_GPIO_LEVEL_IRQ_EN
    .irq_level   (irq_level),
    .irq_pol     (irq_pol),
`endif
    .gpio_in     (gpio_in),
    .irq_pending (irq_pending),
    .gpio_irq    (gpio_irq)
  );

  typedef struct packed {
    logic [N-1:0] gi;
    logic [N-1:0] pd;
    logic         irq;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: pad delayed SYNCW samples; a debounced pin takes the
  // new value once it has been seen db_limit consecutive samples in a row.
  logic [N-1:0] m_dl [SYNCW];
  int           m_run [N];
  logic [N-1:0] m_prev, m_f, m_pend;
  logic         m_irq;

  always @(posedge clk) begin : model
    logic [N-1:0] s, nf, set;
    logic         irq_n;
    exp_t         e;
    if (!nreset) begin
      for (int k = 0; k < SYNCW; k++) m_dl[k] = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_prev = '0; m_f = '0; m_pend = '0; m_irq = 1'b0;
    end else begin
      s = m_dl[SYNCW-1];
      for (int k = SYNCW-1; k > 0; k--) m_dl[k] = m_dl[k-1];
      m_dl[0] = pad_in;
      set = '0;
      for (int i = 0; i < N; i++) begin
        if (s[i] == m_prev[i]) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : 1000;
        else                   m_run[i] = 1;
        m_prev[i] = s[i];
        if (!db_en[i] || db_limit == 0)
          nf[i] = s[i];
        else if (s[i] != m_f[i] && m_run[i] >= int'(db_limit))
          nf[i] = s[i];
        else
          nf[i] = m_f[i];
        if (irq_rise_en[i] && !m_f[i] && nf[i]) set[i] = 1'b1;
        if (irq_fall_en[i] && m_f[i] && !nf[i]) set[i] = 1'b1;
`ifdef LA_GPIO_LEVEL_IRQ_EN
        if (irq_level[i]) set[i] = (m_f[i] == irq_pol[i]);
`endif
      end
      irq_n  = |(m_pend & ~irq_mask);
      m_pend = (m_pend & ~irq_clear) | set;
      m_f    = nf;
      m_irq  = irq_n;
    end
    e.gi  = m_f;
    e.pd  = m_pend;
    e.irq = m_irq;
    sbq.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check("sb_gpio_in", gpio_in, e.gi);
      check("sb_pending", irq_pending, e.pd);
      check("sb_gpio_irq", gpio_irq, e.irq);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    nreset = 1'b0; pad_in = '1; db_en = '0; db_limit = '0;
    irq_rise_en = '1; irq_fall_en = '0; irq_mask = '1; irq_clear = '0;
    irq_level = '0; irq_pol = '0;
    tick(3);
    check("t1_reset_gpio", gpio_in, 0);
    check("t1_reset_pend", irq_pending, 0);
    nreset = 1'b1;
    repeat (SYNCW) @(posedge clk);
    #1 check("t1_pre_gpio", gpio_in, 8'h00);
    @(posedge clk);
    #1 check("t1_gpio", gpio_in, 8'hFF);
    check("t1_pend", irq_pending, 8'hFF);

    @(negedge clk); irq_clear = '1;
    tick(1); irq_clear = '0;

    // glitch filtering on pin 0
    pad_in = '0; db_en = 8'h01; db_limit = 8'd4;
    tick(10);
    pad_in[0] = 1'b1;
    tick(3); pad_in[0] = 1'b0;
    tick(12);
    check("t2_glitch", gpio_in[0], 0);
    check("t2_glitch_pend", irq_pending[0], 0);
    pad_in[0] = 1'b1;
    repeat (SYNCW + 3) @(posedge clk);
    #1 check("t2_pre_rise", gpio_in[0], 0);
    @(negedge clk); pad_in[0] = 1'b0;
    @(posedge clk);
    #1 check("t2_rise", gpio_in[0], 1);
    tick(12);

    // falling edge IRQ on pin 3
    db_en = '0; db_limit = '0; irq_fall_en = 8'h08; irq_mask = '0;
    pad_in[3] = 1'b1;
    tick(6); irq_clear = '1;
    tick(1); irq_clear = '0; pad_in[3] = 1'b0;
    repeat (SYNCW + 1) @(posedge clk);
    #1 check("t3_pend", irq_pending[3], 1);
    check("t3_irq_lag", gpio_irq, 0);
    @(posedge clk);
    #1 check("t3_irq", gpio_irq, 1);
    @(negedge clk); irq_clear = 8'h08;
    @(posedge clk);
    #1 check("t3_clr_pend", irq_pending[3], 0);
    @(negedge clk); irq_clear = '0;
    @(posedge clk);
    #1 check("t3_clr_irq", gpio_irq, 0);

    // async reset mid-debounce, then a fresh full-length count
    @(negedge clk);
    db_en = '0; db_limit = '0; pad_in = '1;
    tick(6);
    db_en = '1; db_limit = 8'd8; pad_in = '0;
    tick(SYNCW + 3);
    #2 nreset = 1'b0;
    #1 check("t6_async_gpio", gpio_in, 0);
    check("t6_async_pend", irq_pending, 0);
    check("t6_async_irq", gpio_irq, 0);
    tick(2);
    nreset = 1'b1; pad_in = '1;
    repeat (SYNCW + 7) @(posedge clk);
    #1 check("t6_pre_rise", gpio_in, 8'h00);
    @(posedge clk);
    #1 check("t6_rise", gpio_in, 8'hFF);

    // randomized phase
    for (int blk = 0; blk < 15; blk++) begin
      @(negedge clk);
      db_en       = N'($urandom);
      db_limit    = DBW'($urandom_range(0, 6));
      irq_rise_en = N'($urandom);
      irq_fall_en = N'($urandom);
      irq_mask    = N'($urandom);
      irq_level   = N'($urandom) & N'($urandom);
      irq_pol     = N'($urandom);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 9) == 0) pad_in[i] = ~pad_in[i];
          irq_clear[i] = ($urandom_range(0, 7) == 0);
        end
        if ($urandom_range(0, 49) == 0) irq_mask = N'($urandom);
        if ($urandom_range(0, 99) == 0) db_limit = DBW'($urandom_range(0, 6));
        if (blk == 7 && c == 100) begin
          #3 nreset = 1'b0;
          tick(2);
          nreset = 1'b1;
        end
      end
    end

    @(negedge clk); irq_clear = '0;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
